// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_t : transmit state machine encoding (IDLE, START, DATA, STOP)
//   baud_div() : clocks per serial bit, rounded to nearest
//   DATA_BITS / STOP_BITS : 8N1 frame shape
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Round-to-nearest divide so the bit period error stays under half a clock.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Producer-side write port of the buffered UART transmitter.
//   wr_req/wr_data : single-cycle byte write strobe and data (producer drives)
//   full/empty     : FIFO occupancy flags (transmitter drives)
//   level          : FIFO entry count, 0..2**ADDR_W
//   overflow       : sticky flag, a write was dropped while full
// master = byte producer, slave = uart_tx_buffered.
interface uart_tx_buffered_if
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
);
  logic                 wr_req;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [ADDR_W:0]      level;
  logic                 overflow;

  modport master (output wr_req, wr_data, input full, empty, level, overflow);
  modport slave  (input wr_req, wr_data, output full, empty, level, overflow);
endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous FIFO for the UART transmitter.
//   clk, rst        : clock, synchronous active-high reset (flushes contents)
//   wr_en, wr_data  : push request; ignored when full
//   rd_en, rd_data  : pop request; rd_data is the stored head entry, valid when !empty
//   full, empty     : registered occupancy flags
//   level           : registered entry count, 0..DEPTH
// A push is judged against the registered full flag, so a push while full is
// dropped even when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W:0]   level_nxt;

  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (wr_acc && !rd_acc) begin
      level_nxt = level + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      level_nxt = level - 1'b1;
    end
  end

  // Storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_nxt;
      full  <= (level_nxt == (ADDR_W + 1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter.
//   clk_50m  : sole clock, rising edge
//   reset    : synchronous active-high reset; aborts any frame in flight
//   wr_bus   : producer write port (wr_req/wr_data in; full/empty/level/overflow out)
//   tx_busy  : high while a start, data or stop bit is on the line
//   uart_tx  : registered serial output, idle high
// Bytes are always queued before transmission; the FSM pops the head in IDLE
// or on the last stop-bit cycle, so queued frames leave with no idle gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32'd50_000_000,
  parameter int unsigned BAUD_RATE  = 32'd115200,
  parameter int          FIFO_DEPTH = 16,
  parameter int          ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                clk_50m,
  input  logic                reset,
  uart_tx_buffered_if.slave   wr_bus,
  output logic                tx_busy,
  output logic                uart_tx
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int          CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int          IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_t            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 overflow_r;

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ADDR_W:0]      fifo_level;

  logic bit_end;
  logic frame_end;
  logic pop;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
  assign pop       = !fifo_empty && ((state == IDLE) || frame_end);

  sync_fifo #(
    .WIDTH  (DATA_BITS),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk_50m),
    .rst     (reset),
    .wr_en   (wr_bus.wr_req),
    .wr_data (wr_bus.wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign wr_bus.full     = fifo_full;
  assign wr_bus.empty    = fifo_empty;
  assign wr_bus.level    = fifo_level;
  assign wr_bus.overflow = overflow_r;

  // Overflow uses the same registered full flag the FIFO uses to drop writes.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (wr_bus.wr_req && fifo_full) begin
      overflow_r <= 1'b1;
    end
  end

  // Shift register is pure datapath: loaded on pop, shifted after each data bit.
  always_ff @(posedge clk_50m) begin
    if (pop) begin
      shift <= fifo_rd_data;
    end else if ((state == DATA) && bit_end) begin
      shift <= shift >> 1;
    end
  end

  // uart_tx is registered, so each transition loads the level of the next bit.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            state   <= START;
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (pop) begin
                state   <= START;
                uart_tx <= 1'b0;
              end else begin
                state   <= IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a fast instance (160 Hz / 10 bd, 16 clocks per bit)
// and a default-rate instance (50 MHz / 115200), each watched by an 8N1 decoder.
module tb_uart_tx_buffered;

  localparam int BD_F = (160 + 10 / 2) / 10;
  localparam int BD_D = (50_000_000 + 115_200 / 2) / 115_200;
  localparam int FR_F = 10 * BD_F;
  localparam int FR_D = 10 * BD_D;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_buffered_if #(.ADDR_W(4)) bus_f ();
  uart_tx_buffered_if #(.ADDR_W(4)) bus_d ();
  logic tx_f, busy_f, tx_d, busy_d;

  uart_tx_buffered #(
    .CLK_FREQ(32'd160), .BAUD_RATE(32'd10), .FIFO_DEPTH(16), .ADDR_W(4)
  ) u_fast (
    .clk_50m(clk), .reset(reset), .wr_bus(bus_f), .tx_busy(busy_f), .uart_tx(tx_f)
  );

  uart_tx_buffered u_dflt (
    .clk_50m(clk), .reset(reset), .wr_bus(bus_d), .tx_busy(busy_d), .uart_tx(tx_d)
  );

  int n_checks = 0;
  int n_pass   = 0;

  byte unsigned rx_f[$], rx_d[$], exp_f[$], exp_d[$];
  int frame_err[2];
  int busy_cyc[2];
  int busy_fall[2];
  bit busy_prev[2];

  always @(negedge clk) begin
    if (busy_f) busy_cyc[0] <= busy_cyc[0] + 1;
    if (busy_d) busy_cyc[1] <= busy_cyc[1] + 1;
    if (busy_prev[0] && !busy_f) busy_fall[0] <= busy_fall[0] + 1;
    if (busy_prev[1] && !busy_d) busy_fall[1] <= busy_fall[1] + 1;
    busy_prev[0] <= busy_f;
    busy_prev[1] <= busy_d;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 200000 cycles");
    $fatal(1, "watchdog");
  end

  function automatic logic get_tx(input int w);    return (w == 0) ? tx_f : tx_d; endfunction
  function automatic logic get_busy(input int w);  return (w == 0) ? busy_f : busy_d; endfunction
  function automatic logic get_empty(input int w); return (w == 0) ? bus_f.empty : bus_d.empty; endfunction
  function automatic logic get_full(input int w);  return (w == 0) ? bus_f.full : bus_d.full; endfunction
  function automatic logic get_ovf(input int w);   return (w == 0) ? bus_f.overflow : bus_d.overflow; endfunction
  function automatic logic [4:0] get_level(input int w); return (w == 0) ? bus_f.level : bus_d.level; endfunction

  // Received vs expected byte streams: 0 when identical, 1000 when lengths differ.
  function automatic int rx_mismatch(input int w);
    int m = 0;
    if (w == 0) begin
      if (rx_f.size() != exp_f.size()) return 1000;
      foreach (rx_f[i]) if (rx_f[i] != exp_f[i]) m++;
    end else begin
      if (rx_d.size() != exp_d.size()) return 1000;
      foreach (rx_d[i]) if (rx_d[i] != exp_d[i]) m++;
    end
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_wr(input int w, input logic req, input logic [7:0] d);
    if (w == 0) begin bus_f.wr_req = req; bus_f.wr_data = d; end
    else        begin bus_d.wr_req = req; bus_d.wr_data = d; end
  endtask

  task automatic clear_q(input int w);
    if (w == 0) begin rx_f.delete(); exp_f.delete(); end
    else        begin rx_d.delete(); exp_d.delete(); end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Independent 8N1 decoder: detect falling edge, sample at mid-bit.
  task automatic monitor(input int w, input int bd);
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && get_tx(w) === 1'b0) begin
        repeat (bd / 2) @(negedge clk);
        if (get_tx(w) !== 1'b0) frame_err[w]++;
        for (int i = 0; i < 8; i++) begin
          repeat (bd) @(negedge clk);
          b[i] = get_tx(w);
        end
        repeat (bd) @(negedge clk);
        if (get_tx(w) !== 1'b1) frame_err[w]++;
        if (w == 0) rx_f.push_back(b); else rx_d.push_back(b);
        prev = 1'b1;
      end else begin
        prev = get_tx(w);
      end
    end
  endtask

  task automatic wait_idle(input int w, input int limit, input string name);
    int n = 0;
    while (!(get_busy(w) === 1'b0 && get_empty(w) === 1'b1) && n < limit) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= limit) $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    else n_pass++;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (tx_f !== 1'b1) $display("FAIL reset_tx: got %b required 1", tx_f); else n_pass++;
    n_checks++; if (busy_f !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy_f); else n_pass++;
    n_checks++; if (bus_f.full !== 1'b0) $display("FAIL reset_full: got %b required 0", bus_f.full); else n_pass++;
    n_checks++; if (bus_f.empty !== 1'b1) $display("FAIL reset_empty: got %b required 1", bus_f.empty); else n_pass++;
    n_checks++; if (bus_f.level !== 5'd0) $display("FAIL reset_level: got %0d required 0", bus_f.level); else n_pass++;
    n_checks++; if (bus_f.overflow !== 1'b0) $display("FAIL reset_ovf: got %b required 0", bus_f.overflow); else n_pass++;
    n_checks++; if (tx_d !== 1'b1 || bus_d.empty !== 1'b1) $display("FAIL reset_dflt: tx=%b empty=%b required 1 1", tx_d, bus_d.empty); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] d = 8'hA5;
    int bc, mis, ferr;
    logic exp_bit;
    clear_q(0);
    exp_f.push_back(d);
    bc = busy_cyc[0]; ferr = frame_err[0]; mis = 0;
    set_wr(0, 1'b1, d); tick(); set_wr(0, 1'b0, 8'h00);
    n_checks++; if (bus_f.empty !== 1'b0 || bus_f.level !== 5'd1) $display("FAIL single_after_write: empty=%b level=%0d required 0 1", bus_f.empty, bus_f.level); else n_pass++;
    tick();
    n_checks++; if (tx_f !== 1'b0 || busy_f !== 1'b1) $display("FAIL single_start: tx=%b busy=%b required 0 1", tx_f, busy_f); else n_pass++;
    for (int i = 0; i < FR_F; i++) begin
      if (i > 0) tick();
      if (i / BD_F == 0) exp_bit = 1'b0;
      else if (i / BD_F == 9) exp_bit = 1'b1;
      else exp_bit = d[i / BD_F - 1];
      if (tx_f !== exp_bit || busy_f !== 1'b1) mis++;
    end
    n_checks++; if (mis != 0) $display("FAIL single_waveform: %0d bad cycles, required 0", mis); else n_pass++;
    tick();
    n_checks++; if (busy_f !== 1'b0 || tx_f !== 1'b1) $display("FAIL single_end: busy=%b tx=%b required 0 1", busy_f, tx_f); else n_pass++;
    wait_idle(0, 100, "single");
    n_checks++; if (busy_cyc[0] - bc != FR_F) $display("FAIL single_busy_len: got %0d required %0d", busy_cyc[0] - bc, FR_F); else n_pass++;
    n_checks++; if (rx_mismatch(0) != 0 || frame_err[0] != ferr) $display("FAIL single_rx: mismatches=%0d frame_errs=%0d required 0 0", rx_mismatch(0), frame_err[0] - ferr); else n_pass++;
    n_checks++; if (bus_f.empty !== 1'b1 || bus_f.overflow !== 1'b0) $display("FAIL single_flags: empty=%b ovf=%b required 1 0", bus_f.empty, bus_f.overflow); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bc, bf;
    clear_q(0);
    bc = busy_cyc[0]; bf = busy_fall[0];
    exp_f.push_back(8'h00); exp_f.push_back(8'h2A);
    set_wr(0, 1'b1, 8'h00); tick(); set_wr(0, 1'b0, 8'h00);
    tick();
    set_wr(0, 1'b1, 8'h2A); tick(); set_wr(0, 1'b0, 8'h00);
    wait_idle(0, 2 * FR_F + 100, "b2b");
    n_checks++; if (busy_cyc[0] - bc != 2 * FR_F) $display("FAIL b2b_busy_len: got %0d required %0d", busy_cyc[0] - bc, 2 * FR_F); else n_pass++;
    n_checks++; if (busy_fall[0] - bf != 1) $display("FAIL b2b_gap: busy fell %0d times required 1", busy_fall[0] - bf); else n_pass++;
    n_checks++; if (rx_mismatch(0) != 0) $display("FAIL b2b_rx: mismatches=%0d required 0", rx_mismatch(0)); else n_pass++;
  endtask

  task automatic test_random_burst();
    int n, bc, bf;
    logic [7:0] d;
    for (int r = 0; r < 3; r++) begin
      pulse_reset();
      clear_q(0);
      n = $urandom_range(1, 17);
      bc = busy_cyc[0]; bf = busy_fall[0];
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        exp_f.push_back(d);
        set_wr(0, 1'b1, d); tick();
      end
      set_wr(0, 1'b0, 8'h00);
      n_checks++; if (bus_f.level !== 5'((n == 1) ? 1 : n - 1)) $display("FAIL burst_level: n=%0d got %0d required %0d", n, bus_f.level, (n == 1) ? 1 : n - 1); else n_pass++;
      wait_idle(0, n * FR_F + 200, "burst");
      n_checks++; if (busy_cyc[0] - bc != n * FR_F || busy_fall[0] - bf != 1) $display("FAIL burst_busy: n=%0d cycles=%0d falls=%0d required %0d 1", n, busy_cyc[0] - bc, busy_fall[0] - bf, n * FR_F); else n_pass++;
      n_checks++; if (rx_mismatch(0) != 0 || bus_f.overflow !== 1'b0) $display("FAIL burst_rx: n=%0d mismatches=%0d ovf=%b required 0 0", n, rx_mismatch(0), bus_f.overflow); else n_pass++;
    end
  endtask

  task automatic test_overflow_burst();
    pulse_reset();
    clear_q(0);
    for (int i = 0; i <= 16; i++) exp_f.push_back(8'(i));
    for (int i = 0; i < 18; i++) begin
      set_wr(0, 1'b1, 8'(i)); tick();
      if (i == 1) begin
        n_checks++; if (busy_f !== 1'b1) $display("FAIL ovf_first_pop: busy=%b required 1", busy_f); else n_pass++;
      end
      if (i == 15) begin
        n_checks++; if (bus_f.full !== 1'b0 || bus_f.level !== 5'd15) $display("FAIL ovf_16th: full=%b level=%0d required 0 15", bus_f.full, bus_f.level); else n_pass++;
      end
      if (i == 16) begin
        n_checks++; if (bus_f.full !== 1'b1 || bus_f.level !== 5'd16 || bus_f.overflow !== 1'b0) $display("FAIL ovf_17th: full=%b level=%0d ovf=%b required 1 16 0", bus_f.full, bus_f.level, bus_f.overflow); else n_pass++;
      end
    end
    set_wr(0, 1'b0, 8'h00);
    n_checks++; if (bus_f.overflow !== 1'b1 || bus_f.level !== 5'd16) $display("FAIL ovf_18th: ovf=%b level=%0d required 1 16", bus_f.overflow, bus_f.level); else n_pass++;
    wait_idle(0, 17 * FR_F + 300, "ovf");
    n_checks++; if (rx_mismatch(0) != 0) $display("FAIL ovf_rx: mismatches=%0d required 0", rx_mismatch(0)); else n_pass++;
    n_checks++; if (bus_f.overflow !== 1'b1) $display("FAIL ovf_sticky: ovf=%b required 1", bus_f.overflow); else n_pass++;
  endtask

  task automatic test_overflow_at_stop();
    logic [7:0] d;
    int bf;
    pulse_reset();
    clear_q(0);
    bf = busy_fall[0];
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      exp_f.push_back(d);
      set_wr(0, 1'b1, d); tick();
    end
    set_wr(0, 1'b0, 8'h00);
    // First frame popped at edge 2, so its last stop cycle ends at edge 2 + one frame.
    repeat (2 + FR_F - 1 - 17) tick();
    n_checks++; if (bus_f.level !== 5'd16 || bus_f.full !== 1'b1 || bus_f.overflow !== 1'b0) $display("FAIL stop_pre: level=%0d full=%b ovf=%b required 16 1 0", bus_f.level, bus_f.full, bus_f.overflow); else n_pass++;
    set_wr(0, 1'b1, 8'($urandom)); tick(); set_wr(0, 1'b0, 8'h00);
    n_checks++; if (bus_f.overflow !== 1'b1 || bus_f.level !== 5'd15 || bus_f.full !== 1'b0) $display("FAIL stop_edge: ovf=%b level=%0d full=%b required 1 15 0", bus_f.overflow, bus_f.level, bus_f.full); else n_pass++;
    wait_idle(0, 17 * FR_F + 300, "stop");
    n_checks++; if (rx_mismatch(0) != 0 || busy_fall[0] - bf != 1) $display("FAIL stop_rx: mismatches=%0d falls=%0d required 0 1", rx_mismatch(0), busy_fall[0] - bf); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int bc;
    pulse_reset();
    clear_q(0);
    for (int i = 0; i < 6; i++) begin
      set_wr(0, 1'b1, 8'($urandom)); tick();
    end
    set_wr(0, 1'b0, 8'h00);
    // Data bit 3 spans edges 66..81 after the first write; land the reset at edge 74.
    repeat (73 - 6) tick();
    n_checks++; if (bus_f.level !== 5'd5 || busy_f !== 1'b1) $display("FAIL rstmid_pre: level=%0d busy=%b required 5 1", bus_f.level, busy_f); else n_pass++;
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (tx_f !== 1'b1 || busy_f !== 1'b0) $display("FAIL rstmid_line: tx=%b busy=%b required 1 0", tx_f, busy_f); else n_pass++;
    n_checks++; if (bus_f.level !== 5'd0 || bus_f.empty !== 1'b1 || bus_f.overflow !== 1'b0) $display("FAIL rstmid_fifo: level=%0d empty=%b ovf=%b required 0 1 0", bus_f.level, bus_f.empty, bus_f.overflow); else n_pass++;
    repeat (200) tick();
    clear_q(0);
    bc = busy_cyc[0];
    repeat (400) tick();
    n_checks++; if (busy_cyc[0] != bc || rx_f.size() != 0 || bus_f.empty !== 1'b1) $display("FAIL rstmid_quiet: busy_cycles=%0d frames=%0d empty=%b required 0 0 1", busy_cyc[0] - bc, rx_f.size(), bus_f.empty); else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [7:0] d;
    int ferr;
    pulse_reset();
    clear_q(0);
    ferr = frame_err[0];
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      exp_f.push_back(d);
      set_wr(0, 1'b1, d); tick(); set_wr(0, 1'b0, 8'h00);
      repeat ($urandom_range(139, 259)) tick();
    end
    wait_idle(0, 20 * FR_F, "stream");
    n_checks++; if (rx_mismatch(0) != 0 || frame_err[0] != ferr) $display("FAIL stream_rx: mismatches=%0d frame_errs=%0d required 0 0", rx_mismatch(0), frame_err[0] - ferr); else n_pass++;
    n_checks++; if (bus_f.overflow !== 1'b0) $display("FAIL stream_ovf: got %b required 0", bus_f.overflow); else n_pass++;
  endtask

  task automatic test_default_rate();
    logic [7:0] d;
    int bc, bf, low;
    pulse_reset();
    clear_q(1);
    bc = busy_cyc[1]; bf = busy_fall[1];
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      if (i == 0) d[0] = 1'b1;
      exp_d.push_back(d);
      set_wr(1, 1'b1, d); tick();
      if (i == 1) begin
        n_checks++; if (tx_d !== 1'b0 || busy_d !== 1'b1) $display("FAIL dflt_start: tx=%b busy=%b required 0 1", tx_d, busy_d); else n_pass++;
      end
    end
    set_wr(1, 1'b0, 8'h00);
    low = 1;
    while (tx_d === 1'b0 && low < 2000) begin low++; tick(); end
    n_checks++; if (low != BD_D) $display("FAIL dflt_bit_period: got %0d required %0d", low, BD_D); else n_pass++;
    wait_idle(1, 3 * FR_D + 500, "dflt");
    n_checks++; if (busy_cyc[1] - bc != 3 * FR_D || busy_fall[1] - bf != 1) $display("FAIL dflt_busy: cycles=%0d falls=%0d required %0d 1", busy_cyc[1] - bc, busy_fall[1] - bf, 3 * FR_D); else n_pass++;
    n_checks++; if (rx_mismatch(1) != 0 || bus_d.overflow !== 1'b0) $display("FAIL dflt_rx: mismatches=%0d ovf=%b required 0 0", rx_mismatch(1), bus_d.overflow); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    set_wr(0, 1'b0, 8'h00);
    set_wr(1, 1'b0, 8'h00);
    fork
      monitor(0, BD_F);
      monitor(1, BD_D);
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_random_burst();
    test_overflow_burst();
    test_overflow_at_stop();
    test_reset_mid_frame();
    test_random_stream();
    test_default_rate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
